// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width,
// ALU opcodes, FSM state encoding and a small flag helper.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_AND = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b10;
    localparam logic [1:0] ALUOP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_zero_f(input logic [DATA_W-1:0] value);
        return (value == '0);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 16-bit ALU shared by both requesters; arithmetic wraps
// modulo 2^16 and no carry or overflow is reported.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic        [1:0]        op,
    output logic signed [DATA_W-1:0] alu_out,
    output logic                     is_zero
);

    always_comb begin
        alu_out = '0;
        unique case (op)
            ALUOP_ADD: alu_out = a + b;
            ALUOP_AND: alu_out = a & b;
            ALUOP_OR:  alu_out = a | b;
            ALUOP_SUB: alu_out = a - b;
            default:   alu_out = '0;
        endcase
    end

    assign is_zero = is_zero_f(alu_out);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a shared
// ALU; one operation in flight, result reported with a one-cycle done pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [1:0]        op0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [1:0]        op1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy
);

    state_t state;
    state_t state_next;

    logic                     grant;
    logic                     win_id;
    logic                     last_id;

    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic        [1:0]        op_p0;
    logic                     id_p0;

    logic signed [DATA_W-1:0] alu_out;
    logic                     alu_zero;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        win_id = req1;
        if (req0 && req1) begin
            win_id = ~last_id;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ST_IDLE;
            last_id <= 1'b1;
            done0   <= 1'b0;
            done1   <= 1'b0;
        end else begin
            state   <= state_next;
            done0   <= (state == ST_DONE) && !id_p0;
            done1   <= (state == ST_DONE) &&  id_p0;
            if (grant) begin
                last_id <= win_id;
            end
        end
    end

    // Stage p0: winner's operands latched at grant, isolated from the inputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= '0;
            id_p0 <= 1'b0;
        end else if (grant) begin
            a_p0  <= win_id ? a1  : a0;
            b_p0  <= win_id ? b1  : b0;
            op_p0 <= win_id ? op1 : op0;
            id_p0 <= win_id;
        end
    end

    alu_arbiter_alu u_alu (
        .a       (a_p0),
        .b       (b_p0),
        .op      (op_p0),
        .alu_out (alu_out),
        .is_zero (alu_zero)
    );

    // Stage p1: ALU output captured in EXEC, held until the next capture.
    always_ff @(posedge CLK) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b0;
        end else if (state == ST_EXEC) begin
            result <= alu_out;
            zero   <= alu_zero;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a behavioural
// model of arbitration order, ALU arithmetic and done timing.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic        done0, done1, zero, busy;
    logic [15:0] result;

    int tests  = 0;
    int failed = 0;
    int last_w = 1;

    alu_arbiter dut (
        .CLK    (CLK),
        .reset  (reset),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .op0    (op0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .op1    (op1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .zero   (zero),
        .busy   (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int x;
        case (op)
            2'b00:   x = (int'(a) + int'(b)) % 65536;
            2'b11:   x = (int'(a) - int'(b) + 65536) % 65536;
            2'b01:   x = int'(a & b);
            default: x = int'(a | b);
        endcase
        return x[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requests must already be presented; runs one full grant-to-done sequence.
    task automatic expect_op(input bit hold);
        int          w;
        logic [15:0] er;
        w  = (req0 && req1) ? ((last_w == 1) ? 0 : 1) : (req0 ? 0 : 1);
        er = (w == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
        @(posedge CLK);
        @(negedge CLK);
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_done", 32'({done0, done1}), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_done", 32'({done0, done1}), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("done_sel", 32'({done0, done1}), (w == 0) ? 32'd2 : 32'd1);
        chk("result", 32'(result), 32'(er));
        chk("zero", 32'(zero), (er == 16'h0000) ? 32'd1 : 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        last_w = w;
        if (!hold) begin
            if (w == 0) req0 = 1'b0;
            else        req1 = 1'b0;
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge CLK);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'({done0, done1}), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        a0 = 16'h1234; b0 = 16'h0001; op0 = ALUOP_ADD;
        a1 = 16'h4321; b1 = 16'h0002; op1 = ALUOP_SUB;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_done", 32'({done0, done1}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b0;
        last_w = 1;
        idle_check(2);

        a0 = 16'd32; b0 = 16'd32; op0 = ALUOP_SUB; req0 = 1'b1;
        expect_op(1'b0);
        idle_check(1);

        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset  = 1'b0;
        last_w = 1;

        a0 = 16'd5;   b0 = 16'd7; op0 = ALUOP_ADD;
        a1 = 16'd100; b1 = 16'd1; op1 = ALUOP_ADD;
        req0 = 1'b1; req1 = 1'b1;
        expect_op(1'b0);
        expect_op(1'b0);

        a0 = 16'($urandom); b0 = 16'($urandom); op0 = 2'($urandom_range(0, 3));
        a1 = 16'($urandom); b1 = 16'($urandom); op1 = 2'($urandom_range(0, 3));
        req0 = 1'b1; req1 = 1'b1;
        expect_op(1'b0);
        expect_op(1'b0);

        a0 = 16'hFFFF; b0 = 16'h0001; op0 = ALUOP_ADD; req0 = 1'b1;
        expect_op(1'b0);

        for (int k = 0; k < 3; k++) begin
            a1 = 16'($urandom); b1 = 16'($urandom); op1 = 2'($urandom_range(0, 3));
            req1 = 1'b1;
            expect_op(k < 2);
        end
        idle_check(2);

        for (int i = 0; i < 16; i++) begin
            if (!req0 && !req1) begin
                int r;
                r = $urandom_range(1, 3);
                if (r[0]) begin
                    a0 = 16'($urandom); b0 = 16'($urandom);
                    op0 = 2'($urandom_range(0, 3)); req0 = 1'b1;
                end
                if (r[1]) begin
                    a1 = 16'($urandom); b1 = 16'($urandom);
                    op1 = 2'($urandom_range(0, 3)); req1 = 1'b1;
                end
            end
            expect_op(1'b0);
        end
        if (req0 || req1) expect_op(1'b0);
        idle_check(1);

        a0 = 16'd3; b0 = 16'd4; op0 = ALUOP_ADD; req0 = 1'b1;
        expect_op(1'b0);

        a0 = 16'd9; b0 = 16'd9; op0 = ALUOP_ADD; req0 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        req0  = 1'b0;
        chk("rexec_busy", 32'(busy), 32'd0);
        chk("rexec_result", 32'(result), 32'd0);
        chk("rexec_zero", 32'(zero), 32'd0);
        chk("rexec_done", 32'({done0, done1}), 32'd0);
        idle_check(3);
        chk("rexec_result_hold", 32'(result), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, taken from the shared package.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; held high until done0.
REQ-005 a0, b0  input  16 each  requester 0 operands; stable while req0 high.
REQ-006 op0  input  2  requester 0 ALU opcode; stable while req0 high.
REQ-007 req1, a1, b1, op1  input  1/16/16/2  requester 1 equivalents of REQ-004..006.
REQ-008 done0  output  1  one-cycle pulse; result/zero valid for requester 0.
REQ-009 done1  output  1  one-cycle pulse; result/zero valid for requester 1.
REQ-010 result  output  16  shared registered ALU result; meaningful only while a done is high.
REQ-011 zero  output  1  registered ALU isZero flag, valid with result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, EXEC, DONE; a single operation is in flight at any time.
REQ-014 IDLE: no req high -> stay IDLE; any req high -> latch winner's a, b, op and winner id, go EXEC.
REQ-015 Arbitration: exactly one req high -> that requester wins; both high -> requester not granted last wins (round-robin).
REQ-016 Round-robin pointer updates only on grant, to the granted id.
REQ-017 EXEC: ALU driven solely from latched operand/opcode registers; alu_out -> result register, isZero -> zero register; go DONE.
REQ-018 DONE: assert done of latched winner id only, for exactly one cycle; go IDLE unconditionally.
REQ-019 Latency: req sampled at edge N -> done high from edge N+2 to edge N+3; next grant no earlier than edge N+3.
REQ-020 result and zero hold their value until the next EXEC capture.
REQ-021 Requester deasserts req on the edge that samples its done high; req still high in IDLE is a new request.
REQ-022 Input changes after latching (EXEC/DONE) do not affect the in-flight operation.
REQ-023 done0 and done1 are never high in the same cycle.
REQ-024 Arithmetic: 16-bit, wrap-around; no carry/overflow outputs; opcode meaning owned by the ALU.

Reset
REQ-025 reset high at a rising edge: state IDLE, done0/done1 0, busy 0, result 0x0000, zero 0, operand/opcode registers 0, pointer = requester 1 (so requester 0 wins first tie).
REQ-026 reset asserted mid-operation drops the in-flight operation; no done pulse produced for it.
REQ-027 reset takes priority over all other activity, including simultaneous req.

Structure
REQ-028 Shared package holds: DATA_W = 16, opcode constants ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b11, FSM state encoding.
REQ-029 Instantiates the existing ALU module as its single sub-module; no other sub-modules.

Verification
REQ-030 Reset: reset high 2 cycles with req0/req1 high -> all outputs 0, busy 0, no done.
REQ-031 Single request: req0, a0=32, b0=32, op0=2'b11 -> done0 at edge N+2, result 0x0000, zero 1; done1 stays 0.
REQ-032 Tie: req0 and req1 together (op ADD, 5+7 and 100+1) -> done0 with 12 first, then done1 with 101; next tie won by requester 0.
REQ-033 Back-to-back: req1 held high over 3 ops, req0 low -> three done1 pulses spaced 3 cycles, busy low one cycle between.
REQ-034 Wrap: a0=0xFFFF, b0=0x0001, op ADD -> result 0x0000, zero 1.
REQ-035 Reset in EXEC: reset asserted one cycle after grant -> no done pulse, state IDLE, result 0.
